// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: operand forwarding select, load-use hazard detection,
// multi-cycle EX op stall sequencing and a saturating stall-cycle counter.
// Forwarding and hazard outputs are combinational so the pipeline reacts in
// the same cycle. Every output is forced low while rst_n is asserted.
module hazard_fwd_ctrl #(
  parameter int REG_AW     = 5,
  parameter int N_STAGES   = 2,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(N_STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [REG_AW-1:0]          ifid_rs,
  input  logic [REG_AW-1:0]          ifid_rt,
  input  logic [REG_AW-1:0]          idex_rs,
  input  logic [REG_AW-1:0]          idex_rt,
  input  logic                       idex_memread,
  input  logic [REG_AW-1:0]          idex_rd,
  input  logic [N_STAGES-1:0]        fwd_we,
  input  logic [N_STAGES*REG_AW-1:0] fwd_rd,
  input  logic                       mc_start,
  input  logic                       stall_cnt_clr,
  output logic [SEL_W-1:0]           fwd_a,
  output logic [SEL_W-1:0]           fwd_b,
  output logic                       stall_if_id,
  output logic                       flush_idex,
  output logic                       hold_ex,
  output logic                       bubble_exmem,
  output logic                       mc_busy,
  output logic [CNT_W-1:0]           stall_cnt
);

  // The multi-cycle latency never exceeds 255, so 8 bits always suffice.
  localparam int MC_CNT_W = 8;
  localparam logic [MC_CNT_W-1:0] MC_BUSY_LEN = MC_CNT_W'(MC_LATENCY - 2);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  logic [MC_CNT_W-1:0] r_mc_cnt;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic [SEL_W-1:0] w_sel_a;
  logic [SEL_W-1:0] w_sel_b;
  logic             w_load_use;
  logic             w_busy;
  logic             w_stall;
  logic             w_hold;
  logic             w_flush;

  // Forwarding select: scan oldest to youngest so the youngest match wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = N_STAGES - 1; k >= 0; k--) begin
      if (fwd_we[k] && (fwd_rd[k*REG_AW +: REG_AW] != '0)) begin
        if (fwd_rd[k*REG_AW +: REG_AW] == idex_rs) w_sel_a = SEL_W'(k + 1);
        if (fwd_rd[k*REG_AW +: REG_AW] == idex_rt) w_sel_b = SEL_W'(k + 1);
      end
    end
  end

  assign w_load_use = idex_memread && (idex_rd != '0) &&
                      ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));

  // A busy multi-cycle op masks both new mc_start and load-use requests;
  // mc_start outranks load-use when both arrive in RUN.
  assign w_busy  = (r_state == ST_MC_BUSY);
  assign w_hold  = w_busy || mc_start;
  assign w_flush = !w_busy && !mc_start && w_load_use;
  assign w_stall = w_hold || w_flush;

  assign fwd_a        = rst_n ? w_sel_a : '0;
  assign fwd_b        = rst_n ? w_sel_b : '0;
  assign stall_if_id  = rst_n && w_stall;
  assign flush_idex   = rst_n && w_flush;
  assign hold_ex      = rst_n && w_hold;
  assign bubble_exmem = rst_n && w_hold;
  assign mc_busy      = rst_n && w_busy;
  assign stall_cnt    = r_stall_cnt;

  // Multi-cycle sequencer: MC_BUSY lasts MC_LATENCY-2 cycles after the start cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_state  <= ST_RUN;
      r_mc_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (mc_start && (MC_LATENCY > 2)) begin
            r_state  <= ST_MC_BUSY;
            r_mc_cnt <= MC_BUSY_LEN;
          end
        end
        ST_MC_BUSY: begin
          r_mc_cnt <= r_mc_cnt - 1'b1;
          if (r_mc_cnt <= MC_CNT_W'(1)) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Saturating stall-cycle counter; a clear request beats an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed scenarios followed by
// random traffic, all compared against a behavioural model of the stall rules.
module tb_hazard_fwd_ctrl;

  localparam int AW    = 5;
  localparam int NS    = 3;
  localparam int LAT   = 4;
  localparam int CW    = 4;
  localparam int SW    = $clog2(NS + 1);
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] ifid_rs = '0, ifid_rt = '0, idex_rs = '0, idex_rt = '0, idex_rd = '0;
  logic idex_memread = 1'b0, mc_start = 1'b0, stall_cnt_clr = 1'b0;
  logic [NS-1:0] fwd_we = '0;
  logic [NS*AW-1:0] fwd_rd = '0;
  logic [SW-1:0] fwd_a, fwd_b;
  logic stall_if_id, flush_idex, hold_ex, bubble_exmem, mc_busy;
  logic [CW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: remaining busy cycles of a multi-cycle op, and stall count.
  int m_busy_left = 0;
  int m_cnt = 0;

  hazard_fwd_ctrl #(.REG_AW(AW), .N_STAGES(NS), .MC_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd),
    .mc_start(mc_start), .stall_cnt_clr(stall_cnt_clr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_if_id(stall_if_id), .flush_idex(flush_idex),
    .hold_ex(hold_ex), .bubble_exmem(bubble_exmem), .mc_busy(mc_busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Youngest stage with a write to a nonzero matching register, as 1-based index.
  function automatic int model_fwd(input logic [AW-1:0] r);
    for (int k = 0; k < NS; k++) begin
      logic [AW-1:0] rd;
      rd = fwd_rd[k*AW +: AW];
      if (fwd_we[k] && rd != 0 && rd == r) return k + 1;
    end
    return 0;
  endfunction

  function automatic bit model_load_use();
    return idex_memread && idex_rd != 0 && (idex_rd == ifid_rs || idex_rd == ifid_rt);
  endfunction

  function automatic void set_rd(input int k, input int v);
    fwd_rd[k*AW +: AW] = AW'(v);
  endfunction

  // Called at a negedge with inputs already applied: check, clock, update model.
  task automatic do_cycle();
    bit busy, lu, stall, hold, flush;
    #1;
    busy  = (m_busy_left > 0);
    lu    = model_load_use();
    hold  = busy || mc_start;
    flush = !busy && !mc_start && lu;
    stall = hold || flush;
    check("fwd_a", 32'(fwd_a), 32'(model_fwd(idex_rs)));
    check("fwd_b", 32'(fwd_b), 32'(model_fwd(idex_rt)));
    check("stall_if_id", 32'(stall_if_id), 32'(stall));
    check("flush_idex", 32'(flush_idex), 32'(flush));
    check("hold_ex", 32'(hold_ex), 32'(hold));
    check("bubble_exmem", 32'(bubble_exmem), 32'(hold));
    check("mc_busy", 32'(mc_busy), 32'(busy));
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    @(posedge clk);
    if (busy) m_busy_left--;
    else if (mc_start) m_busy_left = LAT - 2;
    if (stall_cnt_clr) m_cnt = 0;
    else if (stall && m_cnt < CMAX) m_cnt++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ifid_rs = '0; ifid_rt = '0; idex_rs = '0; idex_rt = '0; idex_rd = '0;
    idex_memread = 1'b0; mc_start = 1'b0; stall_cnt_clr = 1'b0;
    fwd_we = '0; fwd_rd = '0;
  endtask

  initial begin
    // Reset state with nonzero inputs that would otherwise forward and stall.
    fwd_we = '1; set_rd(0, 3); idex_rs = 5'd3; idex_rt = 5'd3; mc_start = 1'b1;
    #12;
    check("rst_fwd_a", 32'(fwd_a), 32'd0);
    check("rst_stall", 32'(stall_if_id), 32'd0);
    check("rst_hold", 32'(hold_ex), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: youngest stage wins; dropping it exposes the older stage.
    fwd_we = 3'b011; set_rd(0, 5); set_rd(1, 5); idex_rs = 5'd5;
    #1 check("t1_youngest", 32'(fwd_a), 32'd1);
    do_cycle();
    fwd_we = 3'b010;
    #1 check("t1_older", 32'(fwd_a), 32'd2);
    do_cycle();

    // 2: register zero never forwards.
    fwd_we = '1; fwd_rd = '0; idex_rs = '0; idex_rt = '0;
    #1 check("t2_fwd_a", 32'(fwd_a), 32'd0);
    check("t2_fwd_b", 32'(fwd_b), 32'd0);
    do_cycle();

    // 3: single-cycle load-use stall, counter 0 -> 1.
    idle_inputs();
    idex_memread = 1'b1; idex_rd = 5'd8; ifid_rt = 5'd8;
    #1 check("t3_flush", 32'(flush_idex), 32'd1);
    do_cycle();
    idle_inputs();
    #1 check("t3_cnt", 32'(stall_cnt), 32'd1);
    do_cycle();

    // 4: mc_start pulse with load-use held high throughout.
    idex_memread = 1'b1; idex_rd = 5'd8; ifid_rs = 5'd8; mc_start = 1'b1;
    do_cycle();
    mc_start = 1'b0;
    for (int i = 0; i < LAT - 2; i++) begin
      #1 check("t4_busy_noflush", 32'(flush_idex), 32'd0);
      do_cycle();
    end
    #1 check("t4_flush_after", 32'(flush_idex), 32'd1);
    do_cycle();

    // 5: saturation after a long load-use hold, then clear.
    for (int i = 0; i < 20; i++) do_cycle();
    #1 check("t5_saturated", 32'(stall_cnt), CMAX);
    stall_cnt_clr = 1'b1;
    do_cycle();
    stall_cnt_clr = 1'b0; idex_memread = 1'b0;
    #1 check("t5_cleared", 32'(stall_cnt), 32'd0);
    do_cycle();

    // 6: asynchronous reset in the middle of a multi-cycle op.
    mc_start = 1'b1;
    do_cycle();
    mc_start = 1'b0; idex_memread = 1'b1;
    fwd_we = 3'b001; set_rd(0, 4); idex_rs = 5'd4;
    #2 rst_n = 1'b0;
    #1;
    check("t6_stall", 32'(stall_if_id), 32'd0);
    check("t6_busy", 32'(mc_busy), 32'd0);
    check("t6_hold", 32'(hold_ex), 32'd0);
    check("t6_flush", 32'(flush_idex), 32'd0);
    check("t6_fwd_a", 32'(fwd_a), 32'd0);
    check("t6_cnt", 32'(stall_cnt), 32'd0);
    m_busy_left = 0; m_cnt = 0;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    do_cycle();

    // Random traffic over a small register range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      ifid_rs = AW'($urandom_range(0, 3)); ifid_rt = AW'($urandom_range(0, 3));
      idex_rs = AW'($urandom_range(0, 3)); idex_rt = AW'($urandom_range(0, 3));
      idex_rd = AW'($urandom_range(0, 3));
      idex_memread = ($urandom_range(0, 2) == 0);
      mc_start = ($urandom_range(0, 7) == 0);
      stall_cnt_clr = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NS; k++) begin
        fwd_we[k] = 1'($urandom_range(0, 1));
        set_rd(k, int'($urandom_range(0, 3)));
      end
      do_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
